nmea_field_capture: RTL

Parametrised NMEA-0183 field extractor that sits between `uart_rx` and the numeric conversion blocks (`speed_extract`, `pace_converter`) in the GPS display pipeline. It matches a configurable sentence ID and captures one configurable comma-delimited field as raw ASCII. It verifies the `*hh` XOR checksum, which the current GPRMC-only parser does not check, and publishes the field only for sentences that pass. Several instances can share one `uart_rx` byte stream to pull different fields or sentences in parallel.

---
 rtl/nmea_field_capture.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/nmea_field_capture.sv
// nmea_field_capture: matches one NMEA sentence ID, captures one field and publishes it after checksum checking
module nmea_field_capture #(
   parameter logic [39:0] SENTENCE_ID   = "GPRMC",
   parameter int          FIELD_IDX     = 7,
   parameter int          MAX_LEN       = 8,
   parameter int          MAX_SENT      = 82,
   parameter bit          REQUIRE_CKSUM = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic [8*MAX_LEN-1:0] field_data,
   output logic [3:0]           field_len,
   output logic                 field_valid,
   output logic                 cksum_err,
   output logic                 overflow
);
   typedef enum logic [2:0] {IDLE, HDR, FIELDS, CK_HI, CK_LO} state_t;
   state_t state, state_n;
   logic [7:0] xor_acc, byte_cnt, fld_cnt;
   logic [2:0] hdr_idx;
   logic [3:0] wr_ptr, ck_hi, hex_val;
   logic [8*MAX_LEN-1:0] cap_buf;
   logic [39:0] id_sh;
   logic bad, is_eol, is_hex, ck_ok, cnt_full, hdr_ok, at_field, reached;
   logic restart, acc, count, cap, mark_bad, hdr_step, fld_inc, hold_hi, pub, err, ovf;
   // classify the incoming byte against the current sentence context
   always_comb begin
      is_eol   = rx_data == 8'h0D || rx_data == 8'h0A;
      is_hex   = (rx_data >= "0" && rx_data <= "9") || (rx_data >= "A" && rx_data <= "F") || (rx_data >= "a" && rx_data <= "f");
      hex_val  = rx_data <= "9" ? rx_data[3:0] : rx_data[3:0] + 4'd9;
      ck_ok    = is_hex && {ck_hi, hex_val} == xor_acc;
      id_sh    = SENTENCE_ID << {hdr_idx, 3'b000};
      hdr_ok   = rx_data == id_sh[39:32];
      cnt_full = int'(byte_cnt) + 2 >= MAX_SENT;
      at_field = int'(fld_cnt) == FIELD_IDX;
      reached  = int'(fld_cnt) >= FIELD_IDX;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   // next state and per-byte datapath controls; a '$' restarts from any state
   always_comb begin
      state_n  = state;
      restart  = 1'b0;
      acc      = 1'b0;
      count    = 1'b0;
      cap      = 1'b0;
      mark_bad = 1'b0;
      hdr_step = 1'b0;
      fld_inc  = 1'b0;
      hold_hi  = 1'b0;
      pub      = 1'b0;
      err      = 1'b0;
      ovf      = 1'b0;
      if (rx_valid) begin
         if (rx_data == "$") begin
            restart = 1'b1;
            state_n = HDR;
         end else begin
            case (state)
               HDR: begin
                  if (is_eol || !hdr_ok) state_n = IDLE;
                  else begin
                     acc      = 1'b1;
                     count    = 1'b1;
                     hdr_step = 1'b1;
                     state_n  = hdr_idx == 3'd4 ? FIELDS : HDR;
                  end
               end
               FIELDS: begin
                  if (is_eol) begin
                     state_n = IDLE;
                     pub     = !REQUIRE_CKSUM && reached && !bad;
                     ovf     = !REQUIRE_CKSUM && reached && bad;
                  end else if (cnt_full) begin
                     state_n = IDLE;
                     ovf     = 1'b1;
                  end else if (rx_data == "*") begin
                     count   = 1'b1;
                     state_n = CK_HI;
                  end else begin
                     acc      = 1'b1;
                     count    = 1'b1;
                     fld_inc  = rx_data == ",";
                     cap      = rx_data != "," && at_field && int'(wr_ptr) < MAX_LEN;
                     mark_bad = rx_data != "," && at_field && int'(wr_ptr) >= MAX_LEN;
                  end
               end
               CK_HI: begin
                  if (is_eol) state_n = IDLE;
                  else if (cnt_full) begin
                     state_n = IDLE;
                     ovf     = 1'b1;
                  end else if (!is_hex) begin
                     state_n = IDLE;
                     err     = 1'b1;
                  end else begin
                     count   = 1'b1;
                     hold_hi = 1'b1;
                     state_n = CK_LO;
                  end
               end
               CK_LO: begin
                  state_n = IDLE;
                  err     = !is_eol && !ck_ok;
                  pub     = !is_eol && ck_ok && reached && !bad;
                  ovf     = !is_eol && ck_ok && reached && bad;
               end
               default: ;
            endcase
         end
      end
   end
   // running XOR, counters, capture buffer and published outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         xor_acc     <= '0;
         byte_cnt    <= '0;
         fld_cnt     <= '0;
         hdr_idx     <= '0;
         wr_ptr      <= '0;
         ck_hi       <= '0;
         bad         <= 1'b0;
         cap_buf     <= '0;
         field_data  <= '0;
         field_len   <= '0;
         field_valid <= 1'b0;
         cksum_err   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         field_valid <= pub;
         cksum_err   <= err;
         overflow    <= ovf;
         if (restart) begin
            xor_acc  <= '0;
            byte_cnt <= '0;
            fld_cnt  <= '0;
            hdr_idx  <= '0;
            wr_ptr   <= '0;
            bad      <= 1'b0;
            cap_buf  <= '0;
         end else begin
            if (acc) xor_acc <= xor_acc ^ rx_data;
            if (count) byte_cnt <= byte_cnt + 8'd1;
            if (hdr_step) hdr_idx <= hdr_idx + 3'd1;
            if (fld_inc && fld_cnt != 8'hFF) fld_cnt <= fld_cnt + 8'd1;
            if (cap) wr_ptr <= wr_ptr + 4'd1;
            if (mark_bad) bad <= 1'b1;
            if (hold_hi) ck_hi <= hex_val;
            for (int i = 0; i < MAX_LEN; i++)
               if (cap && int'(wr_ptr) == i) cap_buf[8*i +: 8] <= rx_data;
         end
         if (pub) begin
            field_data <= cap_buf;
            field_len  <= wr_ptr;
         end
      end
   end
endmodule
